// File: rtl/timer_seq_pkg.sv
// Shared types and constants for the timer sequencer block.
package timer_seq_pkg;

    localparam int DEFAULT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic {
        ONE_SHOT = 1'b0,
        PERIODIC = 1'b1
    } mode_t;

endpackage

// File: rtl/timer_seq_ctrl_if.sv
// Configuration channel of the timer sequencer.
// Handshake: a transfer happens on a rising clk edge where cfg_valid and
// cfg_ready are both high; cfg_period/cfg_mode are sampled on that edge only.
// The master may hold or drop cfg_valid freely; cfg_ready never depends
// combinationally on cfg_valid.
interface timer_seq_ctrl_if import timer_seq_pkg::*; #(
    parameter int W = DEFAULT_W
) ();
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_period;
    logic         cfg_mode;

    modport master (output cfg_valid, output cfg_period, output cfg_mode, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_period, input cfg_mode, output cfg_ready);
endinterface

// File: rtl/counter_w_en.sv
// W-bit synchronous up counter with enable, synchronous clear and
// an all-ones carry flag.
module counter_w_en #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_clr,
    output logic [W-1:0] o_count,
    output logic         o_carry
);
    logic [W-1:0] r_count;

    // Clear wins over enable; wraps naturally at W bits.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_carry = &r_count;
endmodule

// File: rtl/timer_seq_ctrl.sv
// Programmable one-shot / periodic timer with pause, stop and retrigger.
// Priority of controls: rst > stop > start > cfg handshake > pause > counting.
module timer_seq_ctrl import timer_seq_pkg::*; #(
    parameter int W = DEFAULT_W
) (
    input  logic            clk,
    input  logic            rst,
    timer_seq_ctrl_if.slave cfg,
    input  logic            start,
    input  logic            stop,
    input  logic            pause,
    output logic [W-1:0]    count,
    output logic            busy,
    output logic            tick,
    output logic            done,
    output logic [W-1:0]    tick_cnt,
    output state_t          dbg_state
);
    state_t       r_state;
    state_t       w_state_nxt;
    logic [W-1:0] r_period_q;
    mode_t        r_mode_q;
    logic         r_tick;
    logic         r_done;
    logic [W-1:0] r_tick_cnt;
    logic         r_busy;
    logic         r_cfg_ready;

    logic         w_hs;
    logic         w_en;
    logic         w_clr;
    logic         w_tick_nxt;
    logic         w_done_nxt;
    logic [W-1:0] w_tick_cnt_nxt;
    logic [W-1:0] w_count;
    logic         w_carry;
    logic         w_terminal;

    counter_w_en #(.W(W)) u_counter (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_en),
        .i_clr   (w_clr),
        .o_count (w_count),
        .o_carry (w_carry)
    );

    assign w_hs = cfg.cfg_valid & r_cfg_ready;
    // count never exceeds period_q while running; the carry term only
    // guards against a wrap if that ever stopped holding.
    assign w_terminal = (w_count == r_period_q) | w_carry;

    // Next-state and next-output decode, highest priority control first.
    always_comb begin
        w_state_nxt    = r_state;
        w_en           = 1'b0;
        w_clr          = 1'b0;
        w_tick_nxt     = 1'b0;
        w_done_nxt     = r_done;
        w_tick_cnt_nxt = r_tick_cnt;
        if (stop) begin
            w_state_nxt = IDLE;
            w_clr       = 1'b1;
            w_done_nxt  = 1'b0;
        end else if (start) begin
            w_clr          = 1'b1;
            w_tick_cnt_nxt = '0;
            w_done_nxt     = 1'b0;
            w_state_nxt    = (r_state == PAUSED && pause) ? PAUSED : RUN;
        end else if (w_hs) begin
            w_done_nxt  = 1'b0;
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                RUN, PAUSED: begin
                    if (pause) begin
                        w_state_nxt = PAUSED;
                    end else if (w_terminal) begin
                        w_clr          = 1'b1;
                        w_tick_nxt     = 1'b1;
                        w_tick_cnt_nxt = (r_tick_cnt == '1) ? r_tick_cnt : r_tick_cnt + 1'b1;
                        if (r_mode_q == PERIODIC) begin
                            w_state_nxt = RUN;
                        end else begin
                            w_state_nxt = DONE;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        // Leaving PAUSED resumes counting on the same edge.
                        w_state_nxt = RUN;
                        w_en        = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State, configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_period_q  <= '0;
            r_mode_q    <= ONE_SHOT;
            r_tick      <= 1'b0;
            r_done      <= 1'b0;
            r_tick_cnt  <= '0;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
        end else begin
            if (w_hs) begin
                r_period_q <= cfg.cfg_period;
                r_mode_q   <= mode_t'(cfg.cfg_mode);
            end
            r_state     <= w_state_nxt;
            r_tick      <= w_tick_nxt;
            r_done      <= w_done_nxt;
            r_tick_cnt  <= w_tick_cnt_nxt;
            r_busy      <= (w_state_nxt == RUN) || (w_state_nxt == PAUSED);
            r_cfg_ready <= (w_state_nxt == IDLE) || (w_state_nxt == DONE);
        end
    end

    assign cfg.cfg_ready = r_cfg_ready;
    assign count         = w_count;
    assign busy          = r_busy;
    assign tick          = r_tick;
    assign done          = r_done;
    assign tick_cnt      = r_tick_cnt;
    assign dbg_state     = r_state;
endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Bench for timer_seq_ctrl: directed scenarios then random traffic, all
// checked every cycle against a behavioural model of the timer rules.
module tb_timer_seq_ctrl;
    import timer_seq_pkg::*;

    localparam int W    = 8;
    localparam int MAXV = (1 << W) - 1;

    // Clock and reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    timer_seq_ctrl_if #(.W(W)) cfg_if ();

    logic         start;
    logic         stop;
    logic         pause;
    logic [W-1:0] count;
    logic         busy;
    logic         tick;
    logic         done;
    logic [W-1:0] tick_cnt;
    state_t       dbg_state;

    timer_seq_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg       (cfg_if.slave),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .count     (count),
        .busy      (busy),
        .tick      (tick),
        .done      (done),
        .tick_cnt  (tick_cnt),
        .dbg_state (dbg_state)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: timer described by flags and plain integers
    bit   m_act;
    bit   m_pau;
    bit   m_tick;
    bit   m_done;
    bit   m_mode;
    int   m_cnt;
    int   m_per;
    int   m_tcnt;
    logic [W-1:0] exp_q[$];

    task automatic model_update();
        bit hs;
        if (rst) begin
            m_act = 0; m_pau = 0; m_tick = 0; m_done = 0; m_mode = 0;
            m_cnt = 0; m_per = 0; m_tcnt = 0;
        end else begin
            hs = cfg_if.cfg_valid && !m_act;
            if (hs) begin
                m_per  = int'(cfg_if.cfg_period);
                m_mode = cfg_if.cfg_mode;
            end
            m_tick = 0;
            if (stop) begin
                m_act = 0; m_pau = 0; m_cnt = 0; m_done = 0;
            end else if (start) begin
                m_cnt = 0; m_tcnt = 0; m_done = 0;
                m_pau = m_act && m_pau && pause;
                m_act = 1;
            end else if (hs) begin
                m_done = 0;
            end else if (m_act) begin
                if (pause) begin
                    m_pau = 1;
                end else begin
                    m_pau = 0;
                    if (m_cnt == m_per) begin
                        m_cnt  = 0;
                        m_tick = 1;
                        if (m_tcnt < MAXV) m_tcnt++;
                        if (!m_mode) begin
                            m_act  = 0;
                            m_done = 1;
                        end
                    end else begin
                        m_cnt++;
                    end
                end
            end
        end
        exp_q.push_back(m_cnt[W-1:0]);
    endtask

    // Scoreboard compare of every output against the model
    task automatic compare();
        logic [W-1:0] exp_cnt;
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 32'd1, 32'd0);
        end else begin
            exp_cnt = exp_q.pop_front();
            check("count", count, exp_cnt);
        end
        check("busy", busy, m_act);
        check("cfg_ready", cfg_if.cfg_ready, !m_act);
        check("tick", tick, m_tick);
        check("done", done, m_done);
        check("tick_cnt", tick_cnt, m_tcnt);
    endtask

    // Driver: one clock with the currently applied inputs
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic do_cfg(input int period, input bit mode);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_period = period[W-1:0];
        cfg_if.cfg_mode   = mode;
        step();
        cfg_if.cfg_valid  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    int n;

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_period = '0; cfg_if.cfg_mode = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_count", count, 0);
        check("rst_ready", cfg_if.cfg_ready, 1);
        check("rst_busy", busy, 0);

        // Periodic, period 4: tick every 5 cycles
        do_cfg(4, 1'b1);
        pulse_start();
        for (int i = 1; i <= 15; i++) begin
            step();
            if (i == 4) check("per4_cnt4", count, 4);
            if (i == 5) check("per4_tick1", tick, 1);
        end
        check("per4_tickcnt3", tick_cnt, 3);
        do_stop();

        // One-shot, period 3
        do_cfg(3, 1'b0);
        pulse_start();
        repeat (3) step();
        check("os_no_tick_yet", tick, 0);
        step();
        check("os_tick", tick, 1);
        check("os_done", done, 1);
        check("os_busy", busy, 0);
        check("os_count", count, 0);
        check("os_ready", cfg_if.cfg_ready, 1);
        step();
        check("os_done_held", done, 1);
        check("os_single_tick", tick, 0);

        // Pause at count 6 for three cycles, period 10
        do_cfg(10, 1'b1);
        pulse_start();
        repeat (6) step();
        check("pause_at6", count, 6);
        pause = 1'b1;
        repeat (3) begin
            step();
            check("pause_hold", count, 6);
            check("pause_busy", busy, 1);
        end
        pause = 1'b0;
        n = 9;
        while (!tick && n < 100) begin
            step();
            n++;
        end
        check("pause_gap", n, 14);
        do_stop();

        // Period 0 periodic: tick every cycle, tick_cnt saturates
        do_cfg(0, 1'b1);
        pulse_start();
        step();
        check("p0_tick", tick, 1);
        repeat (300) step();
        check("p0_sat", tick_cnt, MAXV);

        // stop and start together: stop wins
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        check("stopstart_busy", busy, 0);
        check("stopstart_cnt", count, 0);

        // Full-range period
        do_cfg(255, 1'b1);
        pulse_start();
        n = 0;
        while (!tick && n < 400) begin
            step();
            n++;
        end
        check("p255_gap", n, 256);

        // Retrigger at count 7
        repeat (7) step();
        check("retrig_at7", count, 7);
        pulse_start();
        check("retrig_cnt0", count, 0);
        check("retrig_busy", busy, 1);
        step();
        check("retrig_cnt1", count, 1);

        // Reset mid-run at count 5
        do_stop();
        do_cfg(20, 1'b1);
        pulse_start();
        repeat (5) step();
        check("rstmid_at5", count, 5);
        rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        check("rstmid_cnt", count, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_tick", tick, 0);
        check("rstmid_done", done, 0);
        check("rstmid_tcnt", tick_cnt, 0);
        check("rstmid_ready", cfg_if.cfg_ready, 1);
        check("rstmid_idle", (dbg_state == IDLE), 1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 40) == 0);
            stop  = ($urandom_range(0, 90) == 0);
            rst   = ($urandom_range(0, 600) == 0);
            if ($urandom_range(0, 12) == 0) pause = ~pause;
            cfg_if.cfg_valid  = ($urandom_range(0, 15) == 0);
            cfg_if.cfg_period = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, MAXV))
                                                            : W'($urandom_range(0, 12));
            cfg_if.cfg_mode   = $urandom_range(0, 1);
            step();
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; cfg_if.cfg_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/timer_seq_ctrl.md
TIMER_SEQ_CTRL -- requirements
Module: timer_seq_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, meaning count/period width in bits.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 SHALL have port cfg_valid  input  1  configuration offered.
REQ-005 SHALL have port cfg_ready  output  1  configuration can be accepted.
REQ-006 SHALL have port cfg_period  input  W  terminal count value.
REQ-007 SHALL have port cfg_mode  input  1  0 = one-shot, 1 = periodic.
REQ-008 SHALL have port start  input  1  start/retrigger pulse.
REQ-009 SHALL have port stop  input  1  abort to idle.
REQ-010 SHALL have port pause  input  1  level; hold count while high.
REQ-011 SHALL have port count  output  W  current count value.
REQ-012 SHALL have port busy  output  1  high in RUN or PAUSED.
REQ-013 SHALL have port tick  output  1  one-cycle pulse at terminal count.
REQ-014 SHALL have port done  output  1  one-shot completion, level.
REQ-015 SHALL have port tick_cnt  output  W  ticks since last start, saturating.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, PAUSED, DONE; all outputs registered.
REQ-017 SHALL drive cfg_ready=1 only in IDLE or DONE; a handshake occurs when cfg_valid&cfg_ready at an edge, latching period_q and mode_q.
REQ-018 SHALL apply the priority rst > stop > start > cfg handshake > pause > counting.
REQ-019 On stop, in any state, SHALL go to IDLE with count=0, done=0, tick=0 at the next edge; tick_cnt is held.
REQ-020 On start in IDLE, DONE or RUN, SHALL load count=0, tick_cnt=0, done=0 and enter RUN; start in RUN is a retrigger.
REQ-021 On start in PAUSED, SHALL behave as in REQ-020 and enter PAUSED if pause=1, else RUN.
REQ-022 If start and a cfg handshake coincide, SHALL use the newly latched period_q/mode_q for that run.
REQ-023 In RUN with pause=0 and count!=period_q, SHALL increment count by 1 per cycle.
REQ-024 In RUN with pause=0 and count==period_q, SHALL set count=0 and tick=1 for exactly one cycle at the next edge, and increment tick_cnt, saturating at 2^W-1.
REQ-025 On terminal count, SHALL stay in RUN if mode_q=1; if mode_q=0, SHALL enter DONE with done=1 held until start, stop, cfg handshake or rst.
REQ-026 Tick period SHALL be period_q+1 cycles; period_q=0 in periodic mode gives tick every cycle with count held at 0.
REQ-027 period_q=2^W-1 SHALL count through the full range with no early wrap; there is no modulo beyond the W-bit compare.
REQ-028 In RUN with pause=1, SHALL enter PAUSED with count frozen; terminal detection is suppressed while paused.
REQ-029 In PAUSED with pause=0, SHALL return to RUN and resume from the frozen count.
REQ-030 SHALL ignore pause in IDLE and DONE.
REQ-031 SHALL drive busy=1 in RUN or PAUSED only.

Reset
REQ-032 On rst, SHALL set state=IDLE, count=0, tick=0, done=0, tick_cnt=0, period_q=0, mode_q=0, cfg_ready=1 at the next edge.
REQ-033 rst asserted mid-run SHALL override all inputs that cycle; no tick is emitted on the reset edge.

Structure
REQ-034 SHALL place the state enum, mode enum (ONE_SHOT, PERIODIC) and default width constant in the shared package timer_seq_pkg.
REQ-035 SHALL instantiate one sub-module, counter_w_en: W-bit synchronous up counter with enable, synchronous clear and carry_out (all ones).

Verification
REQ-036 Periodic W=8: cfg period=4, mode=1, then start -> tick every 5 cycles, count sequence 0..4, tick_cnt 1,2,3...
REQ-037 One-shot: period=3, mode=0, start -> single tick 4 cycles after RUN entry, then done=1, busy=0, count=0, cfg_ready=1.
REQ-038 Pause: period=10, pause high at count=6 for 3 cycles -> count holds at 6, busy=1, tick is delayed by exactly 3 cycles.
REQ-039 Boundaries: period=0 periodic -> tick every cycle; period=255 -> tick after 256 cycles; 300 ticks -> tick_cnt=255.
REQ-040 Priority: stop+start same cycle -> IDLE, count=0; start at count=7 -> count=0 and the run restarts.
REQ-041 Reset mid-run at count=5 -> next cycle IDLE, all outputs 0 except cfg_ready=1.
